// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register-file geometry and
// the write-back source selector used by the register-file write arbiter.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_WB,
      SRC_FIFO,
      SRC_BYPASS
   } wb_src_e;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage

// File: rtl/md_result_fifo.sv
// Small synchronous FIFO holding {rd, data} M-unit results that lost
// arbitration for the register-file write port. DEPTH must be a power of two.
module md_result_fifo
   import riscv_pkg::*;
#(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [REG_ADDR_W-1:0]   push_rd,
   input  logic [XLEN-1:0]         push_data,
   input  logic                    pop,
   output logic [REG_ADDR_W-1:0]   head_rd,
   output logic [XLEN-1:0]         head_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [REG_ADDR_W+XLEN-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]           count_q, count_d;

   // NOTE: every _d gets a default before any branch, so no path infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
   end

   // NOTE: registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; entries are only visible through count/empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {push_rd, push_data};
   end

   assign {head_rd, head_data} = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: pipeline results beat buffered M-unit results,
// with a pending scoreboard for in-flight M ops. Optional: WB_STARVE_GUARD_EN.
module writeback_arbiter
   import riscv_pkg::*;
#(
   parameter int XLEN          = riscv_pkg::XLEN,
   parameter int MD_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wb_valid,
   input  logic [REG_ADDR_W-1:0]  wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   md_valid,
   input  logic [REG_ADDR_W-1:0]  md_rd,
   input  logic [XLEN-1:0]        md_data,
   output logic                   md_ready,
   input  logic                   issue_md_valid,
   input  logic [REG_ADDR_W-1:0]  issue_md_rd,
   output logic [NUM_REGS-1:0]    pending,
   output logic                   stall_req,
   output logic                   wr_en,
   output logic [REG_ADDR_W-1:0]  wr_addr,
   output logic [XLEN-1:0]        wr_data
);

   localparam int CNT_W = $clog2(MD_FIFO_DEPTH) + 1;

   wb_src_e                src;
   logic                   md_fire, fifo_push, fifo_pop, fifo_empty;
   logic                   unused_fifo_full;
   logic [CNT_W-1:0]       fifo_count;
   logic [REG_ADDR_W-1:0]  head_rd;
   logic [XLEN-1:0]        head_data;

   logic                   wr_en_q, wr_en_d, wr_md_q, wr_md_d;
   logic [REG_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]        wr_data_q, wr_data_d;
   logic [NUM_REGS-1:0]    pending_q, pending_d;

   // Ready depends only on registered occupancy (and reset), never on valids.
   assign md_ready = !rst && (fifo_count < CNT_W'(MD_FIFO_DEPTH));
   assign md_fire  = md_valid && md_ready;

   always_comb begin
      src = SRC_NONE;
      if (wb_valid)         src = SRC_WB;
      else if (!fifo_empty) src = SRC_FIFO;
      else if (md_fire)     src = SRC_BYPASS;
   end

   assign fifo_push = md_fire && (src != SRC_BYPASS);
   assign fifo_pop  = (src == SRC_FIFO);

   md_result_fifo #(.XLEN(XLEN), .DEPTH(MD_FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_rd   (md_rd),
      .push_data (md_data),
      .pop       (fifo_pop),
      .head_rd   (head_rd),
      .head_data (head_data),
      .full      (unused_fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      wr_md_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (src)
         SRC_WB:     begin wr_addr_d = wb_rd;   wr_data_d = wb_data;                  end
         SRC_FIFO:   begin wr_addr_d = head_rd; wr_data_d = head_data; wr_md_d = 1'b1; end
         SRC_BYPASS: begin wr_addr_d = md_rd;   wr_data_d = md_data;   wr_md_d = 1'b1; end
         default:    ;
      endcase
      // Writes to x0 are consumed but never reach the register file.
      wr_en_d = (src != SRC_NONE) && (wr_addr_d != '0);
   end

   // A pending bit clears on the edge that commits its M write to the RF.
   always_comb begin
      pending_d = pending_q;
      if (wr_en_q && wr_md_q)
         pending_d = pending_d & ~reg_onehot(wr_addr_q);
      if (issue_md_valid && (issue_md_rd != '0))
         pending_d = pending_d | reg_onehot(issue_md_rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_md_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_md_q   <= wr_md_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         pending_q <= pending_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign pending = pending_q;

`ifdef WB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic            blocked;
   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

   assign blocked = wb_valid && !fifo_empty;

   // Saturates so a single long starvation run yields one stall pulse.
   always_comb begin
      starve_cnt_d = '0;
      if (blocked)
         starve_cnt_d = (starve_cnt_q == SC_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                              : starve_cnt_q + SC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) starve_cnt_q <= '0;
      else     starve_cnt_q <= starve_cnt_d;
   end

   assign stall_req = !rst && blocked && (starve_cnt_q == SC_W'(STARVE_LIMIT - 1));
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter; the starve scenario
// expects a stall pulse only when WB_STARVE_GUARD_EN is defined.
module tb_writeback_arbiter;

   localparam int XLEN = 32;
`ifdef WB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wb_valid = 1'b0;
   logic [4:0]      wb_rd = '0;
   logic [XLEN-1:0] wb_data = '0;
   logic            md_valid = 1'b0;
   logic [4:0]      md_rd = '0;
   logic [XLEN-1:0] md_data = '0;
   logic            md_ready;
   logic            issue_md_valid = 1'b0;
   logic [4:0]      issue_md_rd = '0;
   logic [31:0]     pending;
   logic            stall_req;
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .md_valid       (md_valid),
      .md_rd          (md_rd),
      .md_data        (md_data),
      .md_ready       (md_ready),
      .issue_md_valid (issue_md_valid),
      .issue_md_rd    (issue_md_rd),
      .pending        (pending),
      .stall_req      (stall_req),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid       = 1'b0;
      md_valid       = 1'b0;
      issue_md_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_md_valid = 1'b1;
      issue_md_rd    = rd;
      tick();
      issue_md_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
      checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
      checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
      checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_req); end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_md_ready: got %0b want 0", md_ready); end
      rst = 1'b0;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL post_reset_md_ready: got %0b want 1", md_ready); end
   endtask

   task automatic test_wb_write();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      tick();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wb_write: got en=%0b addr=%0d data=%h want en=1 addr=5 data=deadbeef", wr_en, wr_addr, wr_data); end
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL wb_pending: got %h want 0", pending); end
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wb_idle_en: got %0b want 0", wr_en); end
   endtask

   task automatic test_md_bypass();
      issue(5'd7);
      checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL md_issue_pending: got %h want 00000080", pending); end
      repeat (9) tick();
      md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md_bypass_ready: got %0b want 1", md_ready); end
      tick();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h12345678) begin
         errors++; $display("FAIL md_bypass_write: got en=%0b addr=%0d data=%h want en=1 addr=7 data=12345678", wr_en, wr_addr, wr_data); end
      checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL md_pending_held: got %h want 00000080", pending); end
      tick();
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL md_pending_clear: got %h want 0", pending); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL md_after_en: got %0b want 0", wr_en); end
   endtask

   task automatic test_collision();
      issue(5'd9);
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333_3333;
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h9999_9999;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_n: got %0b want 1", md_ready); end
      tick();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h3333_3333) begin
         errors++; $display("FAIL coll_first: got en=%0b addr=%0d data=%h want en=1 addr=3 data=33333333", wr_en, wr_addr, wr_data); end
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_n1: got %0b want 1", md_ready); end
      checks++; if (pending !== 32'h0000_0200) begin errors++; $display("FAIL coll_pending: got %h want 00000200", pending); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h9999_9999) begin
         errors++; $display("FAIL coll_second: got en=%0b addr=%0d data=%h want en=1 addr=9 data=99999999", wr_en, wr_addr, wr_data); end
      tick();
      checks++; if (pending !== 32'h0 || wr_en !== 1'b0) begin
         errors++; $display("FAIL coll_done: got pending=%h en=%0b want pending=0 en=0", pending, wr_en); end
   endtask

   task automatic test_back_to_back();
      // Per cycle: wb on for cycles 0..3; M result index offered; expected ready and write.
      int         md_idx    [9] = '{0, 1, 2, 2, 2, 2, -1, -1, -1};
      logic       exp_ready [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
      logic       exp_en    [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
      logic [4:0] exp_addr  [9] = '{0, 1, 2, 3, 4, 10, 11, 12, 0};
      logic [31:0] exp_data [9] = '{0, 32'h100, 32'h101, 32'h102, 32'h103,
                                    32'hAAAA_000A, 32'hAAAA_000B, 32'hAAAA_000C, 0};
      issue(5'd10);
      issue(5'd11);
      issue(5'd12);
      for (int c = 0; c < 9; c++) begin
         wb_valid = (c < 4);
         wb_rd    = 5'(c + 1);
         wb_data  = 32'h100 + 32'(c);
         md_valid = (md_idx[c] >= 0);
         md_rd    = 5'(10 + md_idx[c]);
         md_data  = 32'hAAAA_000A + 32'(md_idx[c]);
         checks++; if (md_ready !== exp_ready[c]) begin
            errors++; $display("FAIL b2b_ready c%0d: got %0b want %0b", c, md_ready, exp_ready[c]); end
         checks++; if (wr_en !== exp_en[c] || (exp_en[c] && (wr_addr !== exp_addr[c] || wr_data !== exp_data[c]))) begin
            errors++; $display("FAIL b2b_write c%0d: got en=%0b addr=%0d data=%h want en=%0b addr=%0d data=%h",
                               c, wr_en, wr_addr, wr_data, exp_en[c], exp_addr[c], exp_data[c]); end
         if (c == 4) begin
            checks++; if (pending !== 32'h0000_1C00) begin errors++; $display("FAIL b2b_pending: got %h want 00001c00", pending); end
         end
         checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_stall c%0d: got %0b want 0", c, stall_req); end
         tick();
      end
      idle();
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL b2b_pending_clear: got %h want 0", pending); end
   endtask

   task automatic test_rd_zero();
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
      tick();
      idle();
      checks++; if (wr_en !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL rd0_bypass: got en=%0b pending=%h want en=0 pending=0", wr_en, pending); end
      wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h77;
      tick();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd6) begin
         errors++; $display("FAIL rd0_wb: got en=%0b addr=%0d want en=1 addr=6", wr_en, wr_addr); end
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rd0_drain: got en=%0b want 0", wr_en); end
      issue(5'd13);
      md_valid = 1'b1; md_rd = 5'd13; md_data = 32'hD;
      tick();
      idle();
      checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd13 || wr_data !== 32'hD) begin
         errors++; $display("FAIL rd0_fifo_empty_bypass: got en=%0b addr=%0d data=%h want en=1 addr=13 data=d", wr_en, wr_addr, wr_data); end
      tick();
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rd0_pending: got %h want 0", pending); end
   endtask

   task automatic test_starve();
      for (int c = 0; c < 10; c++) begin
         wb_valid = (c < 9);
         wb_rd    = 5'd1;
         wb_data  = 32'h200 + 32'(c);
         md_valid = (c == 0);
         md_rd    = 5'd0;
         md_data  = 32'hEE;
         #1;
         checks++; if (stall_req !== (GUARD && c == 8)) begin
            errors++; $display("FAIL starve_stall c%0d: got %0b want %0b", c, stall_req, (GUARD && c == 8)); end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_reset_flush();
      issue(5'd4);
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
      md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
      tick();
      wb_rd = 5'd2; wb_data = 32'h2;
      md_rd = 5'd20; md_data = 32'h2020;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL flush_fill_ready: got %0b want 1", md_ready); end
      tick();
      idle();
      rst = 1'b1;
      #1;
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_in_rst: got %0b want 0", md_ready); end
      checks++; if (pending !== 32'h0000_0010) begin errors++; $display("FAIL flush_pending_pre: got %h want 00000010", pending); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0 || pending !== 32'h0 || stall_req !== 1'b0) begin
         errors++; $display("FAIL flush_outputs: got en=%0b addr=%0d data=%h pending=%h stall=%0b want all 0",
                            wr_en, wr_addr, wr_data, pending, stall_req); end
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", md_ready); end
      tick();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL flush_no_drain: got en=%0b want 0", wr_en); end
   endtask

   initial begin
      test_reset();
      test_wb_write();
      test_md_bypass();
      test_collision();
      test_back_to_back();
      test_rd_zero();
      test_starve();
      test_reset_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
